mux_scan_ctrl: RTL
==================

Name: mux_scan_ctrl

Overview:
- Upstream controller for the 4:1 single-bit mux stage.
- Drives the mux select lines (s1, s0) through channels 0..3, waits a programmable settle time on each channel, then samples the mux output y.
- Assembles the four samples into a 4-bit frame and presents it downstream on a valid/ready handshake.
- Supports single-shot and continuous scanning.

Parameters:
- SETTLE_CYCLES, 2: clocks the select is held before sampling y. Legal range 1..15. A value of 0 is treated as 1.
- CNT_W, 4: width of the settle counter. Must be able to hold SETTLE_CYCLES.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a scan. Sampled only in IDLE.
- stop  in  1  abort the scan at the next edge. Priority over all other inputs except reset.
- mode_cont  in  1  sampled with start. 1 = rescan forever, 0 = one frame only.
- mux_y  in  1  output of the 4:1 mux stage.
- sel_s1  out  1  mux select MSB.
- sel_s0  out  1  mux select LSB.
- frame_data  out  4  bit n = y sampled with {s1,s0}=n.
- frame_valid  out  1  frame_data holds an unaccepted frame.
- frame_ready  in  1  downstream accepts the frame when high together with frame_valid.
- busy  out  1  high whenever the state is not IDLE.
- overrun  out  1  sticky flag: a completed frame was dropped.

Behaviour:
- Reset (async assert, sync release): state=IDLE, ch=0, sel_s1/sel_s0=0, frame_data=0, frame_valid=0, busy=0, overrun=0, shadow register=0, cont flag=0.
- FSM states: IDLE, SETTLE, SAMPLE.
- IDLE, start=1 at edge k:
  - state goes to SETTLE; ch=0; {sel_s1,sel_s0}=00; settle counter=0; cont flag=mode_cont; busy=1.
- SETTLE:
  - Counter increments every clock.
  - After SETTLE_CYCLES clocks in SETTLE, go to SAMPLE.
- SAMPLE (one clock):
  - At the closing edge, shadow[ch] <= mux_y.
  - If ch<3: ch++, select updated to the new ch, go to SETTLE.
  - If ch==3: the frame is complete (see below).
- Select outputs always equal ch, registered. They change only on the SAMPLE->SETTLE edge or on the start edge.
- Per-channel time is SETTLE_CYCLES+1 clocks.
- frame_valid rises 4*(SETTLE_CYCLES+1) edges after edge k. Default is 12.
- Frame completion:
  - frame_data <= {mux_y, shadow[2:0]}; frame_valid <= 1.
  - If cont=1 and stop=0: ch=0, select=00, go to SETTLE.
  - Otherwise go to IDLE.
- Handshake:
  - frame_valid and frame_data are held stable until a cycle with frame_ready=1; frame_valid clears at that edge.
  - frame_ready while frame_valid=0 has no effect.
- Frame completion and acceptance on the same edge: the new frame is loaded, frame_valid stays 1, no overrun.
- Frame completion while frame_valid=1 and frame_ready=0: the new frame is dropped, the old data is kept, overrun <= 1. overrun clears only on reset.
- stop=1 in SETTLE or SAMPLE:
  - Next edge goes to IDLE; ch=0; select=00.
  - The partial shadow is discarded (no frame_valid).
  - A frame_valid already asserted is unaffected.
- stop=1 in IDLE has no effect.
- start is ignored while busy.
- mode_cont changing mid-scan has no effect; only the cont flag latched at start is used.
- Reset mid-scan returns everything to the reset values immediately.

Optional Feature:
- Macro: MUX_SCAN_PARITY_EN.
- When defined:
  - Extra output frame_par (1 bit), registered with frame_data and equal to ^frame_data.
  - Reset value 0.
  - Held and updated under exactly the same rules as frame_data, including the drop-on-overrun rule.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset, SETTLE_CYCLES=2, mux driven with i0=0, i1=1, i2=0, i3=1, single-shot start pulse:
   - select sequence 00, 01, 10, 11, each held 3 clocks.
   - frame_data=4'b1010 and frame_valid=1 at 12 edges after start.
   - busy drops at the same edge.
2. Same frame with frame_ready held 0 for 5 clocks, then 1:
   - frame_data is stable at 1010 throughout.
   - frame_valid clears on the ready edge.
   - overrun=0.
3. Continuous mode, inputs changed to i0=1, i1=1, i2=1, i3=0, frame_ready held 0:
   - first frame 0111 is held.
   - second completion sets overrun=1 and frame_data stays 0111.
   - with MUX_SCAN_PARITY_EN, frame_par=1.
4. Continuous mode, frame_ready pulsed exactly on each completion edge:
   - frame_valid stays 1 and frame_data updates to each new frame.
   - overrun stays 0.
5. stop asserted during channel-2 SETTLE:
   - busy=0 and select=00 on the next edge.
   - no frame_valid pulse.
   - a fresh start yields the correct full frame.
6. rst_n pulled low mid-SAMPLE with frame_valid=1:
   - all outputs return to 0 asynchronously.
   - start is ignored for the duration of reset.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// Scan controller for a 4:1 single-bit mux: steps the select lines, samples y per channel,
// and delivers 4-bit frames on a valid/ready handshake. Define MUX_SCAN_PARITY_EN to add frame_par.
module mux_scan_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       mode_cont,
  input  logic       mux_y,
  output logic       sel_s1,
  output logic       sel_s0,
  output logic [3:0] frame_data,
  output logic       frame_valid,
  input  logic       frame_ready,
  output logic       busy,
  output logic       overrun
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic       frame_par
`endif
);

  localparam int              SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(SETTLE_EFF - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       ch_q, ch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       shadow_q, shadow_d;
  logic             cont_q, cont_d;
  logic [3:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             complete;
`ifdef MUX_SCAN_PARITY_EN
  logic             par_q, par_d;
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    cont_d   = cont_q;
    data_d   = data_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    complete = 1'b0;
`ifdef MUX_SCAN_PARITY_EN
    par_d    = par_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETTLE;
          ch_d    = 2'd0;
          cnt_d   = '0;
          cont_d  = mode_cont;
        end
      end
      SETTLE: begin
        if (stop) begin
          state_d = IDLE;
          ch_d    = 2'd0;
          cnt_d   = '0;
        end else if (cnt_q == LAST_CNT) begin
          state_d = SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SAMPLE: begin
        cnt_d = '0;
        // The last channel always closes its frame; stop then only suppresses the rescan.
        if (ch_q == 2'd3) begin
          complete = 1'b1;
          ch_d     = 2'd0;
          state_d  = (cont_q && !stop) ? SETTLE : IDLE;
        end else if (stop) begin
          state_d = IDLE;
          ch_d    = 2'd0;
        end else begin
          shadow_d[ch_q] = mux_y;
          ch_d           = ch_q + 2'd1;
          state_d        = SETTLE;
        end
      end
      default: begin
        state_d = IDLE;
        ch_d    = 2'd0;
        cnt_d   = '0;
      end
    endcase

    if (complete) begin
      if (!valid_q || frame_ready) begin
        data_d  = {mux_y, shadow_q};
        valid_d = 1'b1;
`ifdef MUX_SCAN_PARITY_EN
        par_d   = ^{mux_y, shadow_q};
`endif
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && frame_ready) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ch_q     <= 2'd0;
      cnt_q    <= '0;
      // NOTE: the shadow is small and its value is visible only through frame_data, but it is
      // still reset so a frame can never carry stale or X bits.
      shadow_q <= '0;
      cont_q   <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      cont_q   <= cont_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
`ifdef MUX_SCAN_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign sel_s1      = ch_q[1];
  assign sel_s0      = ch_q[0];
  assign frame_data  = data_q;
  assign frame_valid = valid_q;
  assign busy        = (state_q != IDLE);
  assign overrun     = ovr_q;
`ifdef MUX_SCAN_PARITY_EN
  assign frame_par   = par_q;
`endif

endmodule
